// File: rtl/fir_interpolator.sv
// fir_interpolator -- polyphase FIR upsampler (zero-stuff by INTERP).
//
// The block takes low-rate samples through a valid/ready handshake. It
// produces one filtered output every SAMPLE_DIV clocks. A single multiplier-
// accumulator is shared over time: each output takes TPP MAC cycles for
// phase p, using x[k] * h[p + k*INTERP].
//
// Ports:
//   clk           system clock (MCLK_RATE Hz)
//   reset_n       asynchronous active-low reset
//   coefficients  h[0..FILTER_LENGTH-1], signed Q1.(IW-1), interp gain folded in
//   in_data       signed input sample
//   in_valid      in_data valid
//   in_ready      holding register empty; transfer on in_valid && in_ready
//   out_data      signed filtered output, held between strobes
//   out_valid     one-cycle strobe per output sample
//   underrun      one-cycle pulse when no sample is available at a phase-0 tick
//
// Build option: define FIR_INTERP_SATURATE_EN to clamp out-of-range results
// to the IW-bit signed limits. Without it, the low IW bits are kept (wrap).
module fir_interpolator #(
  parameter int IW            = 16,
  parameter int FILTER_LENGTH = 24,
  parameter int INTERP        = 6,
  parameter int MCLK_RATE     = 53693175,
  parameter int DATA_CLK_OUT  = 288000
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic [FILTER_LENGTH-1:0][IW-1:0]  coefficients,
  input  logic [IW-1:0]                     in_data,
  input  logic                              in_valid,
  output logic                              in_ready,
  output logic [IW-1:0]                     out_data,
  output logic                              out_valid,
  output logic                              underrun
);

  localparam int TPP        = FILTER_LENGTH / INTERP;
  localparam int SAMPLE_DIV = MCLK_RATE / DATA_CLK_OUT;
  localparam int ACC_W      = 2*IW + $clog2(TPP);
  localparam int DIV_W      = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int PH_W       = (INTERP > 1) ? $clog2(INTERP) : 1;
  localparam int K_W        = (TPP > 1) ? $clog2(TPP) : 1;
  localparam int CI_W       = (FILTER_LENGTH > 1) ? $clog2(FILTER_LENGTH) : 1;
  // Rounding constant: half an output LSB, giving round half up.
  localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (IW-2);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_e;

  state_e                   state_q;
  logic [DIV_W-1:0]         div_q;
  logic [PH_W-1:0]          phase_q;
  logic [K_W-1:0]           k_q;
  logic signed [ACC_W-1:0]  acc_q, acc_d;
  logic signed [IW-1:0]     hist_q [TPP];
  logic [IW-1:0]            hold_q;
  logic                     full_q;
  logic [IW-1:0]            out_data_q;
  logic                     out_valid_q, underrun_q;

  logic                     tick, ph0_tick, load;
  logic [IW-1:0]            x_new;
  logic [CI_W-1:0]          cidx;
  logic signed [2*IW-1:0]   prod;
  logic [IW-1:0]            res;

  always_comb begin
    tick     = (div_q == DIV_W'(SAMPLE_DIV-1));
    ph0_tick = (state_q == IDLE) && tick && (phase_q == '0);
    // A sample offered at the phase-0 tick while the buffer is empty bypasses
    // the holding register and goes straight into the history.
    x_new    = full_q ? hold_q : (in_valid ? in_data : '0);
    load     = in_valid && !full_q && !ph0_tick;
    cidx     = CI_W'(phase_q) + CI_W'(k_q * INTERP);
    prod     = $signed(hist_q[k_q]) * $signed(coefficients[cidx]);
    acc_d    = acc_q + ACC_W'(prod);
  end

`ifdef FIR_INTERP_SATURATE_EN
  logic signed [ACC_W-1:0] rshift;
  logic                    ovf;
  assign rshift = (acc_q + RND) >>> (IW-1);
  // In range only when every bit above the IW-bit sign position matches it.
  assign ovf    = !((&rshift[ACC_W-1:IW-1]) || !(|rshift[ACC_W-1:IW-1]));
  assign res    = !ovf ? rshift[IW-1:0]
                : (rshift[ACC_W-1] ? {1'b1, {(IW-1){1'b0}}} : {1'b0, {(IW-1){1'b1}}});
`else
  assign res = IW'((acc_q + RND) >>> (IW-1));
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      div_q       <= '0;
      phase_q     <= '0;
      k_q         <= '0;
      acc_q       <= '0;
      hold_q      <= '0;
      full_q      <= 1'b0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      for (int i = 0; i < TPP; i++) hist_q[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
      div_q       <= tick ? '0 : div_q + DIV_W'(1);
      if (load) begin
        hold_q <= in_data;
        full_q <= 1'b1;
      end
      case (state_q)
        IDLE: if (tick) begin
          if (phase_q == '0) begin
            for (int i = TPP-1; i > 0; i--) hist_q[i] <= hist_q[i-1];
            hist_q[0] <= x_new;
            if (full_q)         full_q     <= 1'b0;
            else if (!in_valid) underrun_q <= 1'b1;
          end
          acc_q   <= '0;
          k_q     <= '0;
          state_q <= MAC;
        end
        MAC: begin
          acc_q <= acc_d;
          if (k_q == K_W'(TPP-1)) state_q <= DONE;
          else                    k_q     <= k_q + K_W'(1);
        end
        DONE: begin
          out_data_q  <= res;
          out_valid_q <= 1'b1;
          phase_q     <= (phase_q == PH_W'(INTERP-1)) ? '0 : phase_q + PH_W'(1);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = !full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_fir_interpolator.sv
// Directed scoreboard bench for fir_interpolator (default parameters:
// TPP=4, SAMPLE_DIV=186). Stimulus pushes hand-computed outputs into exp_q,
// and a negedge monitor pops one entry per out_valid and compares it.
module tb_fir_interpolator;
  localparam int IW = 16, FL = 24, SDIV = 186;

  logic                  clk = 1'b0;
  logic                  reset_n = 1'b0;
  logic [FL-1:0][IW-1:0] coefs = '0;
  logic [IW-1:0]         in_data = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready, out_valid, underrun;
  logic [IW-1:0]         out_data;

  fir_interpolator dut (
    .clk(clk), .reset_n(reset_n), .coefficients(coefs),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct { logic [IW-1:0] d; string name; int idx; } exp_t;
  exp_t exp_q[$];
  int n_checks = 0, n_fail = 0;
  int xfer_cnt = 0, unr_cnt = 0;

  // Monitor: inputs change only just after posedge, so at the negedge
  // in_valid && in_ready means a transfer happens on the coming edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (reset_n) begin
      if (in_valid && in_ready) xfer_cnt++;
      if (underrun) unr_cnt++;
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_out_valid: out_data=%h, nothing expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d) begin
            n_fail++;
            $display("FAIL %s[%0d]: out_data=%h expected %h", e.name, e.idx, out_data, e.d);
          end
        end
      end
    end
  end

  task automatic check(input string nm, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic push_n(input string nm, input logic [IW-1:0] d, input int n, input int base);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.d = d; e.name = nm; e.idx = base + i;
      exp_q.push_back(e);
    end
  endtask

  task automatic assert_rst();
    @(posedge clk); #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic release_rst();
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  task automatic drain(input string nm, input int max_cyc);
    for (int c = 0; c < max_cyc; c++) begin
      if (exp_q.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check({nm, "_pending_outputs"}, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Hold v on the bus until it transfers, then drive 0 (keep_valid) or drop valid.
  task automatic send_one(input logic [IW-1:0] v, input bit keep_valid);
    logic rdy;
    in_valid = 1'b1; in_data = v;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk); rdy = in_ready;
      @(posedge clk); #1;
      if (rdy) break;
    end
    in_data = '0;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  initial begin
    int x0, u0, cnt, lat;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", int'(out_valid), 0);
    check("reset_out_data",  int'(out_data),  0);
    check("reset_underrun",  int'(underrun),  0);
    check("reset_in_ready",  int'(in_ready),  1);

    // DC gain: x=0x2000, h=0x4000 -> each filled history tap adds 0x1000.
    for (int i = 0; i < FL; i++) coefs[i] = 16'h4000;
    in_valid = 1'b1; in_data = 16'h2000;
    push_n("dc", 16'h1000, 6, 0);  push_n("dc", 16'h2000, 6, 6);
    push_n("dc", 16'h3000, 6, 12); push_n("dc", 16'h4000, 6, 18);
    x0 = xfer_cnt;
    release_rst();
    drain("dc", 24*SDIV + 400);
    // One load before the first tick plus one after each of the phase-0 ticks 0,6,12,18.
    check("dc_transfers_24_outputs", xfer_cnt - x0, 5);

    // Impulse: h[i]=i*0x100, x=0x4000 -> output n is n*0x80.
    assert_rst();
    for (int i = 0; i < FL; i++) coefs[i] = 16'(i * 256);
    for (int m = 0; m < 24; m++) push_n("impulse", 16'(m * 128), 1, m);
    push_n("impulse_tail", 16'h0000, 6, 24);
    release_rst();
    send_one(16'h4000, 1'b1);
    drain("impulse", 30*SDIV + 400);

    // Full-scale positive: 1..4 taps of 0x7FFF*0x7FFF, rounded sums
    // 0x7FFE, 0xFFFC, 0x17FFA, 0x1FFF8.
    assert_rst();
    for (int i = 0; i < FL; i++) coefs[i] = 16'h7FFF;
    in_valid = 1'b1; in_data = 16'h7FFF;
    push_n("sat_pos", 16'h7FFE, 6, 0);
`ifdef FIR_INTERP_SATURATE_EN
    push_n("sat_pos", 16'h7FFF, 18, 6);
`else
    push_n("sat_pos", 16'hFFFC, 6, 6); push_n("sat_pos", 16'h7FFA, 6, 12);
    push_n("sat_pos", 16'hFFF8, 6, 18);
`endif
    release_rst();
    drain("sat_pos", 24*SDIV + 400);

    // Full-scale negative: rounded sums -0x7FFF, -0xFFFE, -0x17FFD, -0x1FFFC.
    assert_rst();
    in_data = 16'h8000;
    push_n("sat_neg", 16'h8001, 6, 0);
`ifdef FIR_INTERP_SATURATE_EN
    push_n("sat_neg", 16'h8000, 18, 6);
`else
    push_n("sat_neg", 16'h0002, 6, 6); push_n("sat_neg", 16'h8003, 6, 12);
    push_n("sat_neg", 16'h0004, 6, 18);
`endif
    release_rst();
    drain("sat_neg", 24*SDIV + 400);

    // Underrun: one sample then valid low; it flows through 4 taps, then zeros.
    assert_rst();
    for (int i = 0; i < FL; i++) coefs[i] = 16'h4000;
    in_valid = 1'b0;
    push_n("underrun_data", 16'h1000, 24, 0);
    push_n("underrun_data", 16'h0000, 6, 24);
    x0 = xfer_cnt; u0 = unr_cnt;
    release_rst();
    send_one(16'h2000, 1'b0);
    drain("underrun_data", 30*SDIV + 400);
    check("underrun_pulses_30_outputs", unr_cnt - u0, 4);
    check("underrun_transfers", xfer_cnt - x0, 1);

    // Reset mid-MAC: h[i]=(i+1)*0x100 makes phase p of an impulse read (p+1)*0x80.
    assert_rst();
    for (int i = 0; i < FL; i++) coefs[i] = 16'((i + 1) * 256);
    push_n("pre_reset", 16'h0080, 1, 0); push_n("pre_reset", 16'h0100, 1, 1);
    in_valid = 1'b1; in_data = 16'h4000;
    release_rst();
    send_one(16'h4000, 1'b1);
    cnt = 0;
    for (int c = 0; c < 3*SDIV; c++) begin
      @(posedge clk); #1;
      if (out_valid) cnt++;
      if (cnt == 2) break;
    end
    check("pre_reset_out_valid_count", cnt, 2);
    // The next tick is 180 cycles after this strobe; 182 lands in its MAC.
    repeat (182) @(posedge clk);
    #1 reset_n = 1'b0; in_data = 16'h4000;
    #1;
    check("midmac_out_valid", int'(out_valid), 0);
    check("midmac_out_data",  int'(out_data),  0);
    check("midmac_in_ready",  int'(in_ready),  1);
    for (int m = 0; m < 8; m++) push_n("post_reset", 16'((m + 1) * 128), 1, m);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    lat = 0;
    for (int n = 1; n <= 2*SDIV; n++) begin
      @(posedge clk); #1;
      if (n == 1) in_data = '0;
      if (out_valid) begin lat = n; break; end
    end
    // Released between edges, the tick falls in cycle SDIV-1 and out_valid
    // follows TPP+2 later. Whether the release cycle itself counts moves
    // the figure by one, so both readings are accepted.
    n_checks++;
    if (lat != SDIV + 5 && lat != SDIV + 6) begin
      n_fail++;
      $display("FAIL release_to_out_valid: %0d cycles, expected %0d or %0d", lat, SDIV + 5, SDIV + 6);
    end
    drain("post_reset", 8*SDIV + 400);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
endmodule
